// File: rtl/acx_axil_reg_bridge.sv
// ---------------------------------------------------------------------------
// acx_axil_reg_bridge
//
// AXI4-Lite slave that turns each AXI-Lite read or write into one access on
// the 32-bit configuration register bus. Each access has a fixed shape:
//   1. SETUP  : address and write data are presented on the register bus.
//   2. ACCESS : a one-cycle strobe (o_reg_wr byte strobes or o_reg_rd).
//   3. WAIT   : wait for the registered hit from the addressed register.
//   4. RESP   : return the response on the AXI-Lite B or R channel.
// The register-bus address stays stable from SETUP through RESP and keeps
// its last value while idle.
//
// Each of the AW, W and AR channels has one holding slot. A channel's ready
// is high whenever its slot is empty, so a new AW/W/AR can be accepted while
// another transaction is in flight. When a write (AW and W both held) and a
// read (AR held) are both waiting, they alternate. The write goes first
// after reset.
//
// Optional feature (compile-time macro ACX_AXIL_REG_TIMEOUT_EN):
//   When defined, an access that sees no hit within TIMEOUT_CYCLES WAIT
//   cycles completes with SLVERR, and read data is 0. When undefined, WAIT
//   lasts until a hit arrives, so an unmapped address stalls the bridge.
//
// Parameters:
//   AXI_ADDR_WIDTH  AXI-Lite address width
//   TGT_ADDR_WIDTH  register-bus address width (low bits of the AXI address)
//   TIMEOUT_CYCLES  WAIT cycles without a hit before SLVERR (macro builds only)
//
// Ports:
//   i_clk, i_rstn             clock; synchronous active-low reset
//   s_aw*, s_w*, s_b*         AXI-Lite write address / data / response
//   s_ar*, s_r*               AXI-Lite read address / data
//   o_reg_addr                register-bus address
//   o_reg_wr                  byte write strobes (one-cycle pulse)
//   o_reg_rd                  read strobe (one-cycle pulse)
//   o_reg_wdata               register-bus write data
//   i_reg_hit                 OR of all register address hits (registered)
//   i_reg_rdata               OR-ed register read data
// ---------------------------------------------------------------------------
module acx_axil_reg_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TGT_ADDR_WIDTH = 28,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    // AXI-Lite write address
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    // AXI-Lite write data
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [31:0]               s_wdata,
    input  logic [3:0]                s_wstrb,
    // AXI-Lite write response
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    // AXI-Lite read address
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    // AXI-Lite read data
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [31:0]               s_rdata,
    output logic [1:0]                s_rresp,
    // Register bus
    output logic [TGT_ADDR_WIDTH-1:0] o_reg_addr,
    output logic [3:0]                o_reg_wr,
    output logic                      o_reg_rd,
    output logic [31:0]               o_reg_wdata,
    input  logic                      i_reg_hit,
    input  logic [31:0]               i_reg_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    // Channel slots
    logic aw_pend_q, aw_pend_d;
    logic w_pend_q,  w_pend_d;
    logic ar_pend_q, ar_pend_d;
    logic awready_q, wready_q, arready_q;

    logic [TGT_ADDR_WIDTH-1:0] awaddr_q;
    logic [TGT_ADDR_WIDTH-1:0] araddr_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;

    // Current transaction type and round-robin history
    logic is_wr_q,   is_wr_d;
    logic last_rd_q, last_rd_d;

    // AXI response side
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  bresp_q,  bresp_d;
    logic [1:0]  rresp_q,  rresp_d;
    logic [31:0] rdata_q,  rdata_d;

    // Register-bus side
    logic [TGT_ADDR_WIDTH-1:0] reg_addr_q,  reg_addr_d;
    logic [31:0]               reg_wdata_q, reg_wdata_d;
    logic [3:0]                reg_wr_q,    reg_wr_d;
    logic                      reg_rd_q,    reg_rd_d;

    logic aw_hs, w_hs, ar_hs;
    logic wr_elig, rd_elig;
    logic tmo_hit;

    // Only the low TGT_ADDR_WIDTH address bits reach the register bus.
    logic unused_addr;
    assign unused_addr = ^{s_awaddr, s_araddr};

    assign aw_hs   = s_awvalid & awready_q;
    assign w_hs    = s_wvalid  & wready_q;
    assign ar_hs   = s_arvalid & arready_q;
    assign wr_elig = aw_pend_q & w_pend_q;
    assign rd_elig = ar_pend_q;

`ifdef ACX_AXIL_REG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // The counter holds the number of WAIT cycles already spent without a hit.
    // The last allowed cycle ends the access.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_ACCESS) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_WAIT) && !i_reg_hit && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
`endif

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        ar_pend_d   = ar_pend_q;
        is_wr_d     = is_wr_q;
        last_rd_d   = last_rd_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 4'b0000;
        reg_rd_d    = 1'b0;

        // A handshake can only happen while the slot is empty. A slot is
        // cleared only in RESP, and its ready is low there, so setting and
        // clearing never happen in the same cycle.
        if (aw_hs) aw_pend_d = 1'b1;
        if (w_hs)  w_pend_d  = 1'b1;
        if (ar_hs) ar_pend_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // When both are eligible, serve the write only if the last
                // access served was a read.
                if (wr_elig && (!rd_elig || last_rd_q)) begin
                    state_d     = ST_SETUP;
                    is_wr_d     = 1'b1;
                    last_rd_d   = 1'b0;
                    reg_addr_d  = awaddr_q;
                    reg_wdata_d = wdata_q;
                end else if (rd_elig) begin
                    state_d     = ST_SETUP;
                    is_wr_d     = 1'b0;
                    last_rd_d   = 1'b1;
                    reg_addr_d  = araddr_q;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                if (is_wr_q) begin
                    reg_wr_d = wstrb_q;
                end else begin
                    reg_rd_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_reg_hit) begin
                    state_d = ST_RESP;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_OKAY;
                        rdata_d  = i_reg_rdata;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = 32'h0;
                    end
                end
            end
            ST_RESP: begin
                if (is_wr_q) begin
                    if (s_bready) begin
                        bvalid_d  = 1'b0;
                        aw_pend_d = 1'b0;
                        w_pend_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    if (s_rready) begin
                        rvalid_d  = 1'b0;
                        ar_pend_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            ar_pend_q   <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            is_wr_q     <= 1'b0;
            last_rd_q   <= 1'b1;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= 32'h0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 32'h0;
            reg_wr_q    <= 4'b0000;
            reg_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            ar_pend_q   <= ar_pend_d;
            // Ready follows the next slot state, so a slot that fills at
            // this edge drops ready at the same edge.
            awready_q   <= ~aw_pend_d;
            wready_q    <= ~w_pend_d;
            arready_q   <= ~ar_pend_d;
            is_wr_q     <= is_wr_d;
            last_rd_q   <= last_rd_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
        end
    end

    // Holding registers are qualified by their pending flags, so no reset
    // is needed.
    always_ff @(posedge i_clk) begin
        if (aw_hs) awaddr_q <= s_awaddr[TGT_ADDR_WIDTH-1:0];
        if (ar_hs) araddr_q <= s_araddr[TGT_ADDR_WIDTH-1:0];
        if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
        end
    end

    assign s_awready   = awready_q;
    assign s_wready    = wready_q;
    assign s_arready   = arready_q;
    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_rvalid    = rvalid_q;
    assign s_rresp     = rresp_q;
    assign s_rdata     = rdata_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_wdata = reg_wdata_q;
    assign o_reg_wr    = reg_wr_q;
    assign o_reg_rd    = reg_rd_q;

endmodule

// File: tb/tb_acx_axil_reg_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for acx_axil_reg_bridge.
// Contains a small register-bank responder (16 words at register address
// 0x00-0x3F, registered hit one cycle after the strobe) and a shadow copy
// of the expected register contents. A strobe monitor records each
// register-bus strobe. Build with ACX_AXIL_REG_TIMEOUT_EN to cover the
// timeout path. The design is instantiated with TIMEOUT_CYCLES = 8.
// ---------------------------------------------------------------------------
module tb_acx_axil_reg_bridge;

    localparam int AW  = 32;
    localparam int TW  = 28;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          i_rstn;
    logic          s_awvalid, s_awready;
    logic [AW-1:0] s_awaddr;
    logic          s_wvalid, s_wready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_bvalid, s_bready;
    logic [1:0]    s_bresp;
    logic          s_arvalid, s_arready;
    logic [AW-1:0] s_araddr;
    logic          s_rvalid, s_rready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic [TW-1:0] o_reg_addr;
    logic [3:0]    o_reg_wr;
    logic          o_reg_rd;
    logic [31:0]   o_reg_wdata;
    logic          reg_hit;
    logic [31:0]   reg_rdata;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    acx_axil_reg_bridge #(
        .AXI_ADDR_WIDTH(AW),
        .TGT_ADDR_WIDTH(TW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),         .i_rstn(i_rstn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .o_reg_addr(o_reg_addr), .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd),
        .o_reg_wdata(o_reg_wdata), .i_reg_hit(reg_hit), .i_reg_rdata(reg_rdata)
    );

    // Register-bank responder
    logic [31:0] mem [16];
    logic [31:0] shadow [16];
    bit          hit_en = 1'b1;
    logic        mapped;
    assign mapped = (o_reg_addr[TW-1:6] == '0);

    always @(posedge clk) begin
        if (!i_rstn) reg_hit <= 1'b0;
        else         reg_hit <= hit_en && mapped && ((o_reg_wr != 4'b0) || o_reg_rd);
        reg_rdata <= (o_reg_rd && mapped) ? mem[o_reg_addr[5:2]] : 32'h0;
        if ((o_reg_wr != 4'b0) && mapped && hit_en)
            for (int b = 0; b < 4; b++)
                if (o_reg_wr[b]) mem[o_reg_addr[5:2]][b*8 +: 8] <= o_reg_wdata[b*8 +: 8];
    end

    // Strobe monitor
    int          wr_cnt = 0, rd_cnt = 0, overlap_err = 0, long_err = 0;
    int          last_wr_edge = -1, last_rd_edge = -1;
    logic [3:0]  last_wr_strb;
    logic [TW-1:0] last_wr_addr, last_rd_addr;
    logic [31:0] last_wr_data;
    logic        prev_wr = 1'b0, prev_rd = 1'b0;

    always @(negedge clk) begin
        if ((o_reg_wr != 4'b0) && o_reg_rd) overlap_err <= overlap_err + 1;
        if (((o_reg_wr != 4'b0) && prev_wr) || (o_reg_rd && prev_rd)) long_err <= long_err + 1;
        prev_wr <= (o_reg_wr != 4'b0);
        prev_rd <= o_reg_rd;
        if (o_reg_wr != 4'b0) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_strb <= o_reg_wr;
            last_wr_addr <= o_reg_addr;
            last_wr_data <= o_reg_wdata;
            last_wr_edge <= edge_cnt;
        end
        if (o_reg_rd) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= o_reg_addr;
            last_rd_edge <= edge_cnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shadow_write(input int idx, input logic [31:0] d, input logic [3:0] st);
        for (int b = 0; b < 4; b++)
            if (st[b]) shadow[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int aw_dly, input int w_dly, output int acc);
        bit aw_done, w_done, aw_take, w_take;
        int c;
        aw_done = 0; w_done = 0; c = 0; acc = -1;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        while (!(aw_done && w_done) && c < 100) begin
            if (!aw_done && c >= aw_dly) s_awvalid = 1'b1;
            if (!w_done && c >= w_dly)   s_wvalid  = 1'b1;
            aw_take = s_awvalid && s_awready;
            w_take  = s_wvalid && s_wready;
            tick(); c++;
            if (aw_take) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_take)  begin s_wvalid  = 1'b0; w_done  = 1; end
        end
        if (aw_done && w_done) acc = edge_cnt;
        else begin
            checks++; fails++;
            $display("FAIL write_accept: aw_done=%0d w_done=%0d, required both accepted", aw_done, w_done);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dly, output int acc);
        bit done, take;
        int c;
        done = 0; c = 0; acc = -1;
        s_araddr = a;
        while (!done && c < 100) begin
            if (c >= ar_dly) s_arvalid = 1'b1;
            take = s_arvalid && s_arready;
            tick(); c++;
            if (take) begin s_arvalid = 1'b0; done = 1; end
        end
        if (done) acc = edge_cnt;
        else begin
            checks++; fails++;
            $display("FAIL read_accept: AR not accepted within 100 cycles");
            s_arvalid = 1'b0;
        end
    endtask

    // Presents AW, W and AR together and waits until all three are accepted.
    task automatic accept_all(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] st,
                              input logic [31:0] ra);
        int c;
        bit aw_t, w_t, ar_t;
        c = 0;
        s_awaddr = wa; s_wdata = d; s_wstrb = st; s_araddr = ra;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        while ((s_awvalid || s_wvalid || s_arvalid) && c < 50) begin
            aw_t = s_awvalid && s_awready;
            w_t  = s_wvalid && s_wready;
            ar_t = s_arvalid && s_arready;
            tick(); c++;
            if (aw_t) s_awvalid = 1'b0;
            if (w_t)  s_wvalid  = 1'b0;
            if (ar_t) s_arvalid = 1'b0;
        end
        if (s_awvalid || s_wvalid || s_arvalid) begin
            checks++; fails++;
            $display("FAIL accept_all: channels not accepted within 50 cycles");
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        end
    endtask

    task automatic wait_b(input int limit, input int rdy_dly, output int rise, output logic [1:0] resp);
        int c;
        c = 0; rise = -1; resp = 2'bxx;
        while (!s_bvalid && c < limit) begin tick(); c++; end
        if (s_bvalid) begin
            rise = edge_cnt; resp = s_bresp;
            repeat (rdy_dly) tick();
            s_bready = 1'b1; tick(); s_bready = 1'b0;
        end
    endtask

    task automatic wait_r(input int limit, input int rdy_dly, output int rise,
                          output logic [31:0] data, output logic [1:0] resp);
        int c;
        c = 0; rise = -1; resp = 2'bxx; data = 'x;
        while (!s_rvalid && c < limit) begin tick(); c++; end
        if (s_rvalid) begin
            rise = edge_cnt; resp = s_rresp; data = s_rdata;
            repeat (rdy_dly) tick();
            s_rready = 1'b1; tick(); s_rready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            fails++; $display("FAIL reset_ready: got %b required 000", {s_awready, s_wready, s_arready});
        end
        checks++;
        if ({s_bvalid, s_rvalid, o_reg_rd, o_reg_wr} !== 7'b0) begin
            fails++; $display("FAIL reset_valid_strobe: got %b required 0", {s_bvalid, s_rvalid, o_reg_rd, o_reg_wr});
        end
        checks++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'h0 || o_reg_addr !== '0) begin
            fails++; $display("FAIL reset_data: resp=%b/%b rdata=%h addr=%h required 0", s_bresp, s_rresp, s_rdata, o_reg_addr);
        end
        i_rstn = 1'b1;
        tick();
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            fails++; $display("FAIL ready_after_reset: got %b required 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_write_basic();
        int acc, rise, wr0;
        logic [1:0] resp;
        wr0 = wr_cnt;
        do_write(32'h0000_0010, 32'h1234_5678, 4'hF, 0, 0, acc);
        wait_b(20, 0, rise, resp);
        checks++;
        if (rise - acc !== 4) begin
            fails++; $display("FAIL wr_latency: got %0d edges required 4", rise - acc);
        end
        checks++;
        if (resp !== 2'b00) begin fails++; $display("FAIL wr_bresp: got %b required 00", resp); end
        checks++;
        if (wr_cnt - wr0 !== 1 || last_wr_strb !== 4'hF || last_wr_edge !== acc + 2) begin
            fails++; $display("FAIL wr_strobe: count=%0d strb=%h edge=%0d required 1/f/%0d",
                              wr_cnt - wr0, last_wr_strb, last_wr_edge, acc + 2);
        end
        checks++;
        if (last_wr_data !== 32'h1234_5678 || last_wr_addr !== 28'h10) begin
            fails++; $display("FAIL wr_bus_data: data=%h addr=%h required 12345678/10", last_wr_data, last_wr_addr);
        end
        checks++;
        if (s_bvalid !== 1'b0) begin fails++; $display("FAIL bvalid_clear: got %b required 0", s_bvalid); end
        shadow_write(4, 32'h1234_5678, 4'hF);
    endtask

    task automatic test_read_hold();
        int acc, rise, c;
        logic [1:0] resp;
        logic [31:0] data;
        do_write(32'h0000_0014, 32'hDEAD_BEAF, 4'hF, 0, 0, acc);
        wait_b(20, 0, rise, resp);
        shadow_write(5, 32'hDEAD_BEAF, 4'hF);
        do_read(32'h0000_0014, 0, acc);
        c = 0;
        while (!s_rvalid && c < 20) begin tick(); c++; end
        checks++;
        if (edge_cnt - acc !== 4 || !s_rvalid) begin
            fails++; $display("FAIL rd_latency: got %0d edges rvalid=%b required 4/1", edge_cnt - acc, s_rvalid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== shadow[5]) begin
                fails++; $display("FAIL rd_hold%0d: rvalid=%b rdata=%h required 1/%h", i, s_rvalid, s_rdata, shadow[5]);
            end
        end
        checks++;
        if (s_rresp !== 2'b00 || last_rd_addr !== 28'h14) begin
            fails++; $display("FAIL rd_resp_addr: rresp=%b addr=%h required 00/14", s_rresp, last_rd_addr);
        end
        s_rready = 1'b1; tick(); s_rready = 1'b0;
        checks++;
        if (s_rvalid !== 1'b0) begin fails++; $display("FAIL rvalid_clear: got %b required 0", s_rvalid); end
        data = s_rdata;
    endtask

    task automatic test_w_before_aw();
        int acc, rise, wr0;
        logic [1:0] resp;
        wr0 = wr_cnt;
        do_write(32'h0000_0018, 32'hA5C3_0F96, 4'hF, 2, 0, acc);
        checks++;
        if (wr_cnt !== wr0) begin fails++; $display("FAIL w_first_early_strobe: got %0d strobes required 0", wr_cnt - wr0); end
        wait_b(20, 0, rise, resp);
        checks++;
        if (wr_cnt - wr0 !== 1 || last_wr_data !== 32'hA5C3_0F96 || rise - acc !== 4 || resp !== 2'b00) begin
            fails++; $display("FAIL w_first_write: count=%0d data=%h lat=%0d resp=%b required 1/a5c30f96/4/00",
                              wr_cnt - wr0, last_wr_data, rise - acc, resp);
        end
        shadow_write(6, 32'hA5C3_0F96, 4'hF);
    endtask

    task automatic test_round_robin();
        int acc, rise;
        logic [1:0] resp;
        logic [31:0] data, d1, d2, d3;
        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        // All three channels pending together from reset: write first
        i_rstn = 1'b0; tick();
        i_rstn = 1'b1;
        accept_all(32'h0000_0020, d1, 4'hF, 32'h0000_0020);
        wait_b(30, 0, rise, resp);
        shadow_write(8, d1, 4'hF);
        wait_r(30, 0, rise, data, resp);
        checks++;
        if (last_wr_edge >= last_rd_edge || data !== d1) begin
            fails++; $display("FAIL rr_write_first: wr_edge=%0d rd_edge=%0d rdata=%h required wr<rd, %h",
                              last_wr_edge, last_rd_edge, data, d1);
        end
        // Last access was a write, so the read goes first next time
        do_write(32'h0000_0024, d2, 4'hF, 0, 0, acc);
        wait_b(30, 0, rise, resp);
        shadow_write(9, d2, 4'hF);
        accept_all(32'h0000_0020, d3, 4'hF, 32'h0000_0020);
        wait_r(30, 0, rise, data, resp);
        wait_b(30, 0, rise, resp);
        checks++;
        if (last_rd_edge >= last_wr_edge || data !== d1 || resp !== 2'b00) begin
            fails++; $display("FAIL rr_read_first: wr_edge=%0d rd_edge=%0d rdata=%h bresp=%b required rd<wr, %h, 00",
                              last_wr_edge, last_rd_edge, data, d1, resp);
        end
        shadow_write(8, d3, 4'hF);
    endtask

    task automatic test_random();
        int acc, rise, idx;
        logic [1:0] resp;
        logic [31:0] a, d, data;
        logic [3:0] st;
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 15);
            a = {4'($urandom_range(0, 15)), 22'h0, 4'(idx), 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                st = 4'($urandom_range(1, 15));
                do_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), acc);
                wait_b(30, $urandom_range(0, 3), rise, resp);
                checks++;
                if (rise - acc !== 4 || resp !== 2'b00) begin
                    fails++; $display("FAIL rand_wr%0d: lat=%0d resp=%b required 4/00", i, rise - acc, resp);
                end
                checks++;
                if (last_wr_strb !== st || last_wr_addr !== a[TW-1:0] || last_wr_data !== d) begin
                    fails++; $display("FAIL rand_wr_bus%0d: strb=%h addr=%h data=%h required %h/%h/%h",
                                      i, last_wr_strb, last_wr_addr, last_wr_data, st, a[TW-1:0], d);
                end
                shadow_write(idx, d, st);
            end else begin
                do_read(a, $urandom_range(0, 3), acc);
                wait_r(30, $urandom_range(0, 3), rise, data, resp);
                checks++;
                if (rise - acc !== 4 || resp !== 2'b00) begin
                    fails++; $display("FAIL rand_rd%0d: lat=%0d resp=%b required 4/00", i, rise - acc, resp);
                end
                checks++;
                if (data !== shadow[idx]) begin
                    fails++; $display("FAIL rand_rd_data%0d: got %h required %h", i, data, shadow[idx]);
                end
            end
        end
    endtask

    task automatic test_no_hit();
        int acc, rise, wr0, bcnt;
        logic [1:0] resp;
        logic [31:0] data;
        wr0 = wr_cnt;
`ifdef ACX_AXIL_REG_TIMEOUT_EN
        do_write(32'h0000_0028, $urandom, 4'h0, 0, 0, acc);
        wait_b(40, 0, rise, resp);
        checks++;
        if (rise - acc !== 3 + TMO || resp !== 2'b10 || wr_cnt !== wr0) begin
            fails++; $display("FAIL tmo_write: lat=%0d resp=%b strobes=%0d required %0d/10/0",
                              rise - acc, resp, wr_cnt - wr0, 3 + TMO);
        end
        do_read(32'h0000_1000, 0, acc);
        wait_r(40, 0, rise, data, resp);
        checks++;
        if (rise - acc !== 3 + TMO || resp !== 2'b10 || data !== 32'h0) begin
            fails++; $display("FAIL tmo_read: lat=%0d resp=%b rdata=%h required %0d/10/0",
                              rise - acc, resp, data, 3 + TMO);
        end
`else
        do_write(32'h0000_0028, $urandom, 4'h0, 0, 0, acc);
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (s_bvalid) bcnt++;
        end
        checks++;
        if (bcnt !== 0 || s_awready !== 1'b0 || wr_cnt !== wr0) begin
            fails++; $display("FAIL stall_write: bvalid_cycles=%0d awready=%b strobes=%0d required 0/0/0",
                              bcnt, s_awready, wr_cnt - wr0);
        end
        i_rstn = 1'b0; tick();
        i_rstn = 1'b1; tick();
        rise = 0; resp = 2'b00; data = 32'h0;
`endif
    endtask

    task automatic test_reset_mid();
        int acc, rise, bcnt;
        logic [1:0] resp;
        logic [31:0] data;
        hit_en = 1'b0;
        do_write(32'h0000_0028, 32'h5555_AAAA, 4'hF, 0, 0, acc);
        repeat (5) tick();
        i_rstn = 1'b0;
        tick();
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, o_reg_rd, o_reg_wr} !== 10'b0 ||
            o_reg_addr !== '0 || {s_bresp, s_rresp, s_rdata} !== 36'h0) begin
            fails++; $display("FAIL reset_mid_outputs: ctl=%b addr=%h rdata=%h required all 0",
                              {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, o_reg_rd, o_reg_wr},
                              o_reg_addr, s_rdata);
        end
        i_rstn = 1'b1;
        hit_en = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_bvalid) bcnt++;
        end
        checks++;
        if (bcnt !== 0) begin fails++; $display("FAIL reset_mid_no_bvalid: got %0d cycles required 0", bcnt); end
        do_read(32'h0000_0028, 0, acc);
        wait_r(30, 0, rise, data, resp);
        checks++;
        if (data !== shadow[10] || resp !== 2'b00 || rise - acc !== 4) begin
            fails++; $display("FAIL reset_mid_recover: rdata=%h resp=%b lat=%0d required %h/00/4",
                              data, resp, rise - acc, shadow[10]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
        i_rstn = 1'b0;
        s_awvalid = 1'b0; s_awaddr = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0;
        s_rready = 1'b0;

        test_reset();
        test_write_basic();
        test_read_hold();
        test_w_before_aw();
        test_round_robin();
        test_random();
        test_no_hit();
        test_reset_mid();

        checks++;
        if (overlap_err !== 0 || long_err !== 0) begin
            fails++; $display("FAIL strobe_shape: overlaps=%0d long_pulses=%0d required 0/0", overlap_err, long_err);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
